// File: rtl/skip_mem_ctrl.sv
// Port sequencer for the skip-connection bank: a circular buffer over one frame, shared by a producer and a consumer.
// Optional macro SKIP_RD_PRIO_EN: reads always win contention (default build: round-robin).
module skip_mem_ctrl #(
    parameter int N_adder_tree = 16,
    parameter int addr_width   = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [addr_width:0]         frame_len,
    input  logic                        wr_valid,
    input  logic [N_adder_tree*16-1:0]  wr_data,
    output logic                        wr_gnt,
    input  logic                        rd_req,
    output logic                        rd_gnt,
    output logic                        rd_valid,
    output logic [N_adder_tree*16-1:0]  rd_data,
    output logic [addr_width-1:0]       mem_addr,
    output logic                        mem_wr,
    output logic [N_adder_tree*16-1:0]  mem_din,
    input  logic [N_adder_tree*16-1:0]  mem_dout,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [addr_width:0] depth_c = {1'b1, {addr_width{1'b0}}};

    state_t                  state, next_state;
    logic [addr_width:0]     frame_len_q;
    logic [addr_width-1:0]   wr_ptr, rd_ptr;
    logic [addr_width:0]     wr_cnt, rd_cnt, occ;
    logic                    rd_pend;
    logic                    w_el, r_el;

`ifndef SKIP_RD_PRIO_EN
    typedef enum logic {
        GNT_READ  = 1'b0,
        GNT_WRITE = 1'b1
    } gnt_t;

    gnt_t last_gnt;
`endif

    // A read is in flight from its grant until its rd_valid cycle has passed.
    wire read_in_flight = rd_pend | rd_valid;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        w_el       = 1'b0;
        r_el       = 1'b0;
        wr_gnt     = 1'b0;
        rd_gnt     = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                w_el = wr_valid && (wr_cnt < frame_len_q) && (occ < depth_c);
                r_el = rd_req && (rd_cnt < wr_cnt);
                if (w_el && r_el) begin
`ifdef SKIP_RD_PRIO_EN
                    rd_gnt = 1'b1;
`else
                    if (last_gnt == GNT_READ) wr_gnt = 1'b1;
                    else                      rd_gnt = 1'b1;
`endif
                end else begin
                    wr_gnt = w_el;
                    rd_gnt = r_el;
                end
                if ((rd_cnt == frame_len_q) && !read_in_flight) next_state = FIN;
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_len_q <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            occ         <= '0;
            rd_pend     <= 1'b0;
            rd_valid    <= 1'b0;
            mem_addr    <= '0;
            mem_wr      <= 1'b0;
            mem_din     <= '0;
        end else begin
            rd_pend  <= rd_gnt;
            rd_valid <= rd_pend;
            mem_wr   <= 1'b0;

            if ((state == IDLE) && start) begin
                frame_len_q <= frame_len;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                wr_cnt      <= '0;
                rd_cnt      <= '0;
                occ         <= '0;
            end

            if (wr_gnt) begin
                mem_addr <= wr_ptr;
                mem_wr   <= 1'b1;
                mem_din  <= wr_data;
                wr_ptr   <= wr_ptr + 1'b1;
                wr_cnt   <= wr_cnt + 1'b1;
            end

            // Pointers wrap naturally at DEPTH; rd_cnt < wr_cnt keeps reads behind writes across the wrap.
            if (rd_gnt) begin
                mem_addr <= rd_ptr;
                rd_ptr   <= rd_ptr + 1'b1;
                rd_cnt   <= rd_cnt + 1'b1;
            end

            if (wr_gnt && !rd_gnt)      occ <= occ + 1'b1;
            else if (rd_gnt && !wr_gnt) occ <= occ - 1'b1;
        end
    end

`ifndef SKIP_RD_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last_gnt <= GNT_READ;
        else if (wr_gnt) last_gnt <= GNT_WRITE;
        else if (rd_gnt) last_gnt <= GNT_READ;
    end
`endif

    assign rd_data = mem_dout;
    assign busy    = (state != IDLE);
    assign done    = (state == FIN);

endmodule

// File: tb/tb_skip_mem_ctrl.sv
// Randomized bench for skip_mem_ctrl: a bank model plus a frame-level reference model of grants, addresses and read returns.
`timescale 1ns/1ps
module tb_skip_mem_ctrl;

    localparam int NT    = 2;
    localparam int AW    = 3;
    localparam int W     = NT * 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   frame_len = '0;
    logic          wr_valid = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          wr_gnt;
    logic          rd_req = 1'b0;
    logic          rd_gnt;
    logic          rd_valid;
    logic [W-1:0]  rd_data;
    logic [AW-1:0] mem_addr;
    logic          mem_wr;
    logic [W-1:0]  mem_din;
    logic [W-1:0]  mem_dout;
    logic          busy;
    logic          done;

    skip_mem_ctrl #(.N_adder_tree(NT), .addr_width(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_din(mem_din), .mem_dout(mem_dout),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Single-port bank with 1-cycle synchronous read
    logic [W-1:0] bank [DEPTH];
    always @(posedge clk) begin
        if (mem_wr) bank[mem_addr] <= mem_din;
        mem_dout <= bank[mem_addr];
    end

    typedef enum int {M_IDLE, M_RUN, M_DONE} m_state_t;
    m_state_t     m_state = M_IDLE;
    int           m_len, m_wcnt, m_rcnt, m_addr, cyc;
    bit           m_last_read = 1'b1;
    int           ret_q[$];
    logic [W-1:0] data_q[$];
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        start    = 1'b0;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        #1;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din", mem_din, 0);
        check("rst_wr_gnt", wr_gnt, 0);
        check("rst_rd_gnt", rd_gnt, 0);
        m_state     = M_IDLE;
        m_wcnt      = 0;
        m_rcnt      = 0;
        m_addr      = 0;
        m_last_read = 1'b1;
        ret_q.delete();
        data_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive, check combinational outputs, advance the model, check registered outputs.
    task automatic step(input bit st, input bit wv, input bit rq, input int fl);
        bit           exp_w, exp_r, w_el, r_el, inflight, exp_rv;
        logic [W-1:0] wd, exp_data;
        @(negedge clk);
        wd        = $urandom;
        start     = st;
        wr_valid  = wv;
        rd_req    = rq;
        wr_data   = wd;
        frame_len = fl[AW:0];
        #1;
        exp_w = 1'b0;
        exp_r = 1'b0;
        if (m_state == M_RUN) begin
            w_el = wv && (m_wcnt < m_len) && ((m_wcnt - m_rcnt) < DEPTH);
            r_el = rq && (m_rcnt < m_wcnt);
            if (w_el && r_el) begin
`ifdef SKIP_RD_PRIO_EN
                exp_r = 1'b1;
`else
                if (m_last_read) exp_w = 1'b1;
                else             exp_r = 1'b1;
`endif
            end else begin
                exp_w = w_el;
                exp_r = r_el;
            end
        end
        check("wr_gnt", wr_gnt, exp_w);
        check("rd_gnt", rd_gnt, exp_r);
        check("busy", busy, m_state != M_IDLE);
        check("done", done, m_state == M_DONE);

        inflight = ret_q.size() > 0;
        exp_rv   = inflight && (ret_q[0] == cyc);
        check("rd_valid", rd_valid, exp_rv);
        if (exp_rv) begin
            void'(ret_q.pop_front());
            exp_data = data_q.pop_front();
            check("rd_data", rd_data, exp_data);
        end

        case (m_state)
            M_IDLE: if (st) begin
                m_state = M_RUN;
                m_len   = fl;
                m_wcnt  = 0;
                m_rcnt  = 0;
            end
            M_RUN:  if ((m_rcnt == m_len) && !inflight) m_state = M_DONE;
            M_DONE: m_state = M_IDLE;
            default: m_state = M_IDLE;
        endcase
        if (exp_w) begin
            data_q.push_back(wd);
            m_addr      = m_wcnt % DEPTH;
            m_wcnt++;
            m_last_read = 1'b0;
        end
        if (exp_r) begin
            ret_q.push_back(cyc + 2);
            m_addr      = m_rcnt % DEPTH;
            m_rcnt++;
            m_last_read = 1'b1;
        end

        @(posedge clk);
        cyc++;
        #1;
        check("mem_wr", mem_wr, exp_w);
        check("mem_addr", mem_addr, m_addr);
        if (exp_w) check("mem_din", mem_din, wd);
        start = 1'b0;
    endtask

    task automatic run_frame(input int len, input int wpct, input int rpct,
                             input int rd_delay, input int wr_delay, input bit poke_start);
        int n;
        bit wv, rq, st;
        n = 0;
        step(1'b1, 1'b0, 1'b0, len);
        while (m_state != M_IDLE) begin
            wv = (n >= wr_delay) && (($urandom_range(1, 100) <= wpct) || (n > 200));
            rq = (n >= rd_delay) && (($urandom_range(1, 100) <= rpct) || (n > 200));
            st = poke_start && ($urandom_range(0, 7) == 0);
            step(st, wv, rq, $urandom_range(0, 15));
            n++;
            if (n > 400) begin
                check("frame_cycles", n, 400);
                do_reset();
            end
        end
    endtask

    initial begin
        cyc = 0;
        do_reset();

        run_frame(4, 100, 100, 6, 0, 1'b0);    // write all, then read all
        run_frame(8, 100, 100, 0, 0, 1'b0);    // continuous contention
        run_frame(10, 100, 100, 14, 0, 1'b0);  // fill, stall, wrap
        run_frame(5, 100, 100, 0, 4, 1'b0);    // consumer waits on empty
        run_frame(0, 100, 100, 0, 0, 1'b0);    // empty frame
        run_frame(12, 60, 60, 0, 0, 1'b1);     // start pokes during RUN

        // Abort mid-frame, then nothing may come back
        step(1'b1, 1'b0, 1'b0, 9);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, i > 1, 0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 0);

        for (int f = 0; f < 25; f++)
            run_frame($urandom_range(0, 15), $urandom_range(30, 100), $urandom_range(30, 100),
                      $urandom_range(0, 10), $urandom_range(0, 5), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
